// File: rtl/noc_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_packet_arbiter
//
// Round-robin arbiter that merges packet streams from N_REQ sources onto one
// output port. A grant is packet-atomic: once a head flit is accepted, the port
// stays locked to that requester until its tail flit has been accepted. The
// accepted flit is registered in a single-entry output stage, so the
// arbitration logic never sits combinationally on the downstream path.
//
// Handshake rule, used on every port: a flit moves when valid and ready are
// both high at a rising clock edge. A source holds valid and data stable until
// it is accepted. This block never drops out_valid before out_ready is seen.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset, synchronous release
//   in_valid   per-requester flit valid
//   in_data    packed flits; requester i uses bits [i*WIDTH +: WIDTH]
//   in_last    per-requester tail-flit flag
//   in_ready   per-requester accept (at most one bit high)
//   out_valid  output flit valid
//   out_data   output flit
//   out_last   output tail flag
//   out_id     source requester of the output flit
//   out_ready  downstream accept
//   pkt_count  packets whose tail was accepted on the input side (wraps)
// -----------------------------------------------------------------------------
module noc_rr_packet_arbiter #(
    parameter int N_REQ = 14,
    parameter int WIDTH = 18,
    parameter int IDW   = 4,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       in_valid,
    input  logic [N_REQ*WIDTH-1:0] in_data,
    input  logic [N_REQ-1:0]       in_last,
    output logic [N_REQ-1:0]       in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [IDW-1:0]         out_id,
    input  logic                   out_ready,
    output logic [CNTW-1:0]        pkt_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_ptr_next;
    logic [IDW-1:0] lock_id;
    logic [IDW-1:0] lock_id_next;

    logic [IDW-1:0] winner;
    logic           any_valid;
    logic [IDW:0]   cand;
    logic [IDW-1:0] sel_id;
    logic           space;
    logic           grant_en;
    logic           xfer;
    logic           sel_last;
    logic [WIDTH-1:0] sel_data;

    // Rotating priority search starting at rr_ptr. The loop runs from the
    // lowest priority position to the highest so that the last hit, which
    // overrides earlier ones, is the first valid requester at or after rr_ptr.
    // rr_ptr is always below N_REQ, so a single conditional subtract wraps.
    always_comb begin : rr_search
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (cand >= (IDW + 1)'(N_REQ)) begin
                cand = cand - (IDW + 1)'(N_REQ);
            end
            if (in_valid[cand]) begin
                winner    = cand[IDW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    // The stage can take a flit when it is empty or being drained this cycle.
    assign space = !out_valid || out_ready;

    // While locked the holder keeps in_ready even if it is momentarily idle,
    // so other requesters can never slip in mid-packet.
    assign sel_id   = (state == LOCKED) ? lock_id : winner;
    assign grant_en = rst_n && space && ((state == LOCKED) || any_valid);
    assign in_ready = grant_en ? (N_REQ'(1) << sel_id) : '0;
    assign xfer     = grant_en && in_valid[sel_id];
    assign sel_last = in_last[sel_id];
    assign sel_data = in_data[sel_id*WIDTH +: WIDTH];

    always_comb begin : next_state
        state_next   = state;
        rr_ptr_next  = rr_ptr;
        lock_id_next = lock_id;
        if (xfer) begin
            if (sel_last) begin
                state_next  = IDLE;
                rr_ptr_next = (sel_id == IDW'(N_REQ - 1)) ? '0 : sel_id + 1'b1;
            end else if (state == IDLE) begin
                state_next   = LOCKED;
                lock_id_next = sel_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lock_id   <= '0;
            pkt_count <= '0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_ptr_next;
            lock_id <= lock_id_next;
            if (xfer && sel_last) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

    // Fill has priority over drain: a simultaneous drain and fill overwrites
    // the stage and keeps out_valid high for one flit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin : out_stage
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_id    <= sel_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
